shape_editor: RTL and testbench

SHAPE_EDITOR -- requirements
Module: shape_editor

---
 rtl/tangram_pkg.sv | 27 ++
 rtl/wrap_step.sv | 35 +++
 rtl/shape_editor.sv | 201 ++++++++++++++++++++
 tb/tb_shape_editor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tangram_pkg.sv
// Shared types and constants for the shape editor: FSM states, button/mode
// encodings, angle bounds and the default shape size.
package tangram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int ANGLE_MIN = -180;
  localparam int ANGLE_MAX = 179;
  localparam int DEF_SIZE  = 10;

  // Bit positions inside the {c,d,u,r,l} button vectors
  localparam int B_L = 0;
  localparam int B_R = 1;
  localparam int B_U = 2;
  localparam int B_D = 3;
  localparam int B_C = 4;

  localparam logic [1:0] M_MOVE  = 2'd0;
  localparam logic [1:0] M_SHAPE = 2'd1;
  localparam logic [1:0] M_EDIT  = 2'd2;
  localparam logic [1:0] M_COLOR = 2'd3;

endpackage

// File: rtl/wrap_step.sv
// Signed add of a step to a bounded value; the result either saturates at
// [LO, HI] or wraps circularly around that range.
module wrap_step #(
  parameter int W    = 16,
  parameter int LO   = 0,
  parameter int HI   = 255,
  parameter bit WRAP = 1'b0
) (
  input  logic signed [W-1:0] val,
  input  logic signed [W-1:0] delta,
  output logic signed [W-1:0] res
);

  localparam logic signed [W+1:0] LO_S   = (W+2)'(LO);
  localparam logic signed [W+1:0] HI_S   = (W+2)'(HI);
  localparam logic signed [W+1:0] SPAN_S = (W+2)'(HI - LO + 1);

  logic signed [W+1:0] sum_s;
  logic signed [W+1:0] adj_s;

  // Widened sum followed by saturate or single-span wrap (|delta| <= span)
  always_comb begin
    sum_s = (W+2)'(val) + (W+2)'(delta);
    if (sum_s > HI_S) begin
      adj_s = WRAP ? (sum_s - SPAN_S) : HI_S;
    end else if (sum_s < LO_S) begin
      adj_s = WRAP ? (sum_s + SPAN_S) : LO_S;
    end else begin
      adj_s = sum_s;
    end
  end

  assign res = W'(adj_s);

endmodule

// File: rtl/shape_editor.sv
// Frame-paced shape editor: buttons captured between frames are applied once
// per frame to the selected slot; all per-shape fields are held in registers.
module shape_editor
  import tangram_pkg::*;
#(
  parameter int MAXSHP       = 4,
  parameter int INTW         = 16,
  parameter int PIXLW        = 12,
  parameter int SCR_W        = 800,
  parameter int SCR_H        = 600,
  parameter int NTYPES       = 1,
  parameter int SIZE_MAX     = 255,
  parameter int STEP_FAST    = 4,
  parameter int ACCEL_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic [1:0]              mode,
  input  logic [4:0]              btn_held,
  input  logic [4:0]              btn_dn,
  input  logic [PIXLW-1:0]        pick_color,
  output logic [MAXSHP*INTW-1:0]  s_x,
  output logic [MAXSHP*INTW-1:0]  s_y,
  output logic [MAXSHP*INTW-1:0]  s_size,
  output logic [MAXSHP*INTW-1:0]  s_angle,
  output logic [MAXSHP*INTW-1:0]  s_ty,
  output logic [MAXSHP*PIXLW-1:0] s_color,
  output logic [INTW-1:0]         count,
  output logic [INTW-1:0]         sel
);

  localparam int IDXW = (MAXSHP > 1) ? $clog2(MAXSHP) : 1;
  localparam logic [INTW-1:0]  ZERO    = INTW'(0);
  localparam logic [INTW-1:0]  ONE     = INTW'(1);
  localparam logic [INTW-1:0]  TWO     = INTW'(2);
  localparam logic [INTW-1:0]  MAX_C   = INTW'(MAXSHP);
  localparam logic [INTW-1:0]  CX      = INTW'(SCR_W / 2);
  localparam logic [INTW-1:0]  CY      = INTW'(SCR_H / 2);
  localparam logic [INTW-1:0]  DSZ     = INTW'(DEF_SIZE);
  localparam logic [INTW-1:0]  ACC     = INTW'(ACCEL_FRAMES);
  localparam logic [INTW-1:0]  FAST    = INTW'(STEP_FAST);
  localparam logic [INTW-1:0]  LAST_TY = INTW'(NTYPES - 1);
  localparam logic [PIXLW-1:0] WHITE   = {PIXLW{1'b1}};
  localparam logic [PIXLW-1:0] BLANK   = {PIXLW{1'b0}};

  state_t            state_r, state_n_s;
  logic [4:0]        pend_r;
  logic [1:0]        last_mode_r;
  logic [INTW-1:0]   hold_r, count_r, sel_r;
  logic [INTW-1:0]   x_r [MAXSHP];
  logic [INTW-1:0]   y_r [MAXSHP];
  logic [INTW-1:0]   size_r [MAXSHP];
  logic [INTW-1:0]   ang_r [MAXSHP];
  logic [INTW-1:0]   ty_r [MAXSHP];
  logic [PIXLW-1:0]  color_r [MAXSHP];

  logic [IDXW-1:0]   si_s;
  logic              apply_s, mode_chg_s, dir_held_s, add_s, rem_s, nxt_s;
  logic [INTW-1:0]   step_s, cnt_n_s, sel_a_s, sel_n_s, ty_nx_s;
  logic signed [INTW-1:0] d_lr_s, d_ud_s, dx_s, dy_s, dsz_s, dang_s;
  logic [INTW-1:0]   nx_s, ny_s, nsz_s, nang_s;

  assign si_s       = sel_r[IDXW-1:0];
  assign apply_s    = (state_r == ST_APPLY);
  assign mode_chg_s = (mode != last_mode_r);
  assign dir_held_s = |btn_held[3:0];
  // Remove wins over add when both are pending in the same frame
  assign rem_s = apply_s && (mode == M_EDIT) && pend_r[B_L] && (count_r > ONE);
  assign add_s = apply_s && (mode == M_EDIT) && pend_r[B_R] && !pend_r[B_L] && (count_r < MAX_C);
  assign nxt_s = apply_s && (mode == M_EDIT) && pend_r[B_C];
  assign ty_nx_s = (ty_r[si_s] == LAST_TY) ? ZERO : (ty_r[si_s] + ONE);

  // Frame sequencer next-state
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:  state_n_s = frame ? ST_APPLY : ST_IDLE;
      ST_APPLY: state_n_s = ST_DONE;
      ST_DONE:  state_n_s = ST_IDLE;
      default:  state_n_s = ST_IDLE;
    endcase
  end

  // Step size and signed deltas per field; u moves up the screen but grows size
  always_comb begin
    step_s = (!mode_chg_s && (hold_r >= ACC)) ? FAST : ONE;
    if (btn_held[B_L])      d_lr_s = -$signed(step_s);
    else if (btn_held[B_R]) d_lr_s = $signed(step_s);
    else                    d_lr_s = $signed(ZERO);
    if (btn_held[B_U])      d_ud_s = -$signed(step_s);
    else if (btn_held[B_D]) d_ud_s = $signed(step_s);
    else                    d_ud_s = $signed(ZERO);
    dx_s   = (mode == M_MOVE)  ? d_lr_s  : $signed(ZERO);
    dy_s   = (mode == M_MOVE)  ? d_ud_s  : $signed(ZERO);
    dang_s = (mode == M_SHAPE) ? d_lr_s  : $signed(ZERO);
    dsz_s  = (mode == M_SHAPE) ? -d_ud_s : $signed(ZERO);
  end

  // Slot count and selection after add/remove/advance
  always_comb begin
    cnt_n_s = count_r;
    sel_a_s = sel_r;
    if (rem_s) begin
      cnt_n_s = count_r - ONE;
      sel_a_s = (sel_r == count_r - ONE) ? (count_r - TWO) : sel_r;
    end else if (add_s) begin
      cnt_n_s = count_r + ONE;
    end else begin
      cnt_n_s = count_r;
    end
    sel_n_s = nxt_s ? ((sel_a_s == cnt_n_s - ONE) ? ZERO : (sel_a_s + ONE)) : sel_a_s;
  end

  wrap_step #(.W(INTW), .LO(0), .HI(SCR_W - 1), .WRAP(1'b0)) u_x (
    .val(x_r[si_s]), .delta(dx_s), .res(nx_s));
  wrap_step #(.W(INTW), .LO(0), .HI(SCR_H - 1), .WRAP(1'b0)) u_y (
    .val(y_r[si_s]), .delta(dy_s), .res(ny_s));
  wrap_step #(.W(INTW), .LO(0), .HI(SIZE_MAX), .WRAP(1'b0)) u_size (
    .val(size_r[si_s]), .delta(dsz_s), .res(nsz_s));
  wrap_step #(.W(INTW), .LO(ANGLE_MIN), .HI(ANGLE_MAX), .WRAP(1'b1)) u_ang (
    .val(ang_r[si_s]), .delta(dang_s), .res(nang_s));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_n_s;
  end

  // Pending presses, hold counter, mode history, count and selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= 5'd0;
      hold_r      <= ZERO;
      last_mode_r <= 2'd0;
      count_r     <= ONE;
      sel_r       <= ZERO;
    end else begin
      case (state_r)
        ST_IDLE:  pend_r <= pend_r | btn_dn;
        ST_DONE:  pend_r <= 5'd0;
        default:  pend_r <= pend_r;
      endcase
      if (apply_s) begin
        last_mode_r <= mode;
        count_r     <= cnt_n_s;
        sel_r       <= sel_n_s;
        if (mode_chg_s || mode[1] || !dir_held_s) hold_r <= ZERO;
        else if (hold_r < ACC)                    hold_r <= hold_r + ONE;
        else                                      hold_r <= hold_r;
      end
    end
  end

  // Per-slot field storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXSHP; i++) begin
        x_r[i]     <= (i == 0) ? CX : ZERO;
        y_r[i]     <= (i == 0) ? CY : ZERO;
        size_r[i]  <= (i == 0) ? DSZ : ZERO;
        ang_r[i]   <= ZERO;
        ty_r[i]    <= ZERO;
        color_r[i] <= (i == 0) ? WHITE : BLANK;
      end
    end else if (apply_s) begin
      for (int i = 0; i < MAXSHP; i++) begin
        if (add_s && (INTW'(i) == count_r)) begin
          x_r[i]     <= CX;
          y_r[i]     <= CY;
          size_r[i]  <= DSZ;
          ang_r[i]   <= ZERO;
          ty_r[i]    <= ZERO;
          color_r[i] <= WHITE;
        end else if (rem_s && (INTW'(i) == count_r - ONE)) begin
          color_r[i] <= BLANK;
        end else if (INTW'(i) == sel_r) begin
          x_r[i]    <= nx_s;
          y_r[i]    <= ny_s;
          size_r[i] <= nsz_s;
          ang_r[i]  <= nang_s;
          if ((mode == M_SHAPE) && pend_r[B_C]) ty_r[i] <= ty_nx_s;
          if ((mode == M_COLOR) && btn_held[B_C]) color_r[i] <= pick_color;
        end
      end
    end
  end

  for (genvar g = 0; g < MAXSHP; g++) begin : g_flat
    assign s_x[g*INTW +: INTW]       = x_r[g];
    assign s_y[g*INTW +: INTW]       = y_r[g];
    assign s_size[g*INTW +: INTW]    = size_r[g];
    assign s_angle[g*INTW +: INTW]   = ang_r[g];
    assign s_ty[g*INTW +: INTW]      = ty_r[g];
    assign s_color[g*PIXLW +: PIXLW] = color_r[g];
  end

  assign count = count_r;
  assign sel   = sel_r;

endmodule

// File: tb/tb_shape_editor.sv
// Directed-vector bench for shape_editor with default parameters.
module tb_shape_editor;

  logic        clk = 1'b0;
  logic        rst_n, frame;
  logic [1:0]  mode;
  logic [4:0]  btn_held, btn_dn;
  logic [11:0] pick_color;
  logic [63:0] s_x, s_y, s_size, s_angle, s_ty;
  logic [47:0] s_color;
  logic [15:0] count, sel;

  int total = 0;
  int bad   = 0;
  int ey, ea, stp;

  shape_editor dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .mode(mode),
    .btn_held(btn_held), .btn_dn(btn_dn), .pick_color(pick_color),
    .s_x(s_x), .s_y(s_y), .s_size(s_size), .s_angle(s_angle), .s_ty(s_ty),
    .s_color(s_color), .count(count), .sel(sel)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] fu(input logic [63:0] v, input int i);
    return {16'd0, v[i*16 +: 16]};
  endfunction

  function automatic logic signed [31:0] fa(input logic [63:0] v, input int i);
    return 32'($signed(v[i*16 +: 16]));
  endfunction

  function automatic logic signed [31:0] fc(input logic [47:0] v, input int i);
    return {20'd0, v[i*12 +: 12]};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk) btn_dn = b;
    @(negedge clk) btn_dn = 5'd0;
  endtask

  task automatic do_frame();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; frame = 1'b0; mode = 2'd0;
    btn_held = 5'd0; btn_dn = 5'd0; pick_color = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst_count", fu({48'd0, count}, 0), 1);
    chk("rst_sel", fu({48'd0, sel}, 0), 0);
    chk("rst_x0", fu(s_x, 0), 400);
    chk("rst_y0", fu(s_y, 0), 300);
    chk("rst_size0", fu(s_size, 0), 10);
    chk("rst_angle0", fa(s_angle, 0), 0);
    chk("rst_color0", fc(s_color, 0), 12'hFFF);
    chk("rst_color1", fc(s_color, 1), 0);
    chk("rst_x1", fu(s_x, 1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0: hold u, 1/frame for 30 frames then 4/frame, floor at 0
    btn_held = 5'b00100;
    ey = 300;
    for (int f = 0; f < 100; f++) begin
      do_frame();
      stp = (f < 30) ? 1 : 4;
      ey = (ey - stp < 0) ? 0 : ey - stp;
      chk("y_hold_up", fu(s_y, 0), ey);
    end
    btn_held = 5'd0;
    mode = 2'd1;
    do_frame();
    chk("y_floor", fu(s_y, 0), 0);

    // Mode 1: hold l, angle wraps below -180 to reach 178
    btn_held = 5'b00001;
    ea = 0;
    for (int f = 0; f < 68; f++) begin
      do_frame();
      stp = (f < 30) ? 1 : 4;
      ea = ea - stp;
      if (ea < -180) ea = ea + 360;
      chk("angle_hold_l", fa(s_angle, 0), ea);
    end
    chk("angle178", fa(s_angle, 0), 178);
    btn_held = 5'd0;
    do_frame();
    btn_held = 5'b00010;
    do_frame(); chk("angle_179", fa(s_angle, 0), 179);
    do_frame(); chk("angle_m180", fa(s_angle, 0), -180);
    do_frame(); chk("angle_m179", fa(s_angle, 0), -179);
    btn_held = 5'b00100;
    do_frame(); chk("size_up", fu(s_size, 0), 11);
    btn_held = 5'b01100;
    do_frame(); chk("size_u_over_d", fu(s_size, 0), 12);
    btn_held = 5'd0;
    press(5'b10000); do_frame();
    chk("type_wrap", fu(s_ty, 0), 0);
    chk("angle_kept", fa(s_angle, 0), -179);

    // Mode 2: adds up to the slot limit, then remove+add in one frame
    mode = 2'd2;
    for (int k = 0; k < 4; k++) begin
      press(5'b00010); do_frame();
      chk("add_count", fu({48'd0, count}, 0), (k + 2 > 4) ? 4 : k + 2);
    end
    chk("add_x1", fu(s_x, 1), 400);
    chk("add_size1", fu(s_size, 1), 10);
    chk("add_color3", fc(s_color, 3), 12'hFFF);
    press(5'b00011); do_frame();
    chk("rem_add_count", fu({48'd0, count}, 0), 3);
    chk("rem_color3", fc(s_color, 3), 0);
    chk("keep_color2", fc(s_color, 2), 12'hFFF);

    // Selection walk and remove of the selected last slot
    press(5'b10000); do_frame(); chk("sel_1", fu({48'd0, sel}, 0), 1);
    press(5'b10000); do_frame(); chk("sel_2", fu({48'd0, sel}, 0), 2);
    press(5'b00001); do_frame();
    chk("rem_count2", fu({48'd0, count}, 0), 2);
    chk("rem_sel1", fu({48'd0, sel}, 0), 1);
    press(5'b10000); do_frame(); chk("sel_wrap0", fu({48'd0, sel}, 0), 0);
    press(5'b10000); do_frame(); chk("sel_b1", fu({48'd0, sel}, 0), 1);
    press(5'b10000); do_frame(); chk("sel_b0", fu({48'd0, sel}, 0), 0);
    press(5'b10000); do_frame(); chk("sel_c1", fu({48'd0, sel}, 0), 1);

    // Mode 3: colour pick into slot 1 only
    mode = 2'd3;
    pick_color = 12'h0F0;
    btn_held = 5'b10000;
    do_frame();
    btn_held = 5'd0;
    chk("pick_color1", fc(s_color, 1), 12'h0F0);
    chk("pick_color0", fc(s_color, 0), 12'hFFF);

    // Remove down to one slot, then removes/adds at count 1 do nothing
    mode = 2'd2;
    press(5'b00001); do_frame();
    chk("rem_count1", fu({48'd0, count}, 0), 1);
    chk("rem_sel0", fu({48'd0, sel}, 0), 0);
    chk("rem_color1", fc(s_color, 1), 0);
    press(5'b00011); do_frame();
    chk("min_count", fu({48'd0, count}, 0), 1);
    chk("min_color0", fc(s_color, 0), 12'hFFF);

    // Reset asserted during APPLY: asynchronous clear and no edit
    mode = 2'd0;
    btn_held = 5'b00010;
    @(negedge clk) frame = 1'b1;
    @(negedge clk) begin frame = 1'b0; rst_n = 1'b0; end
    #1;
    chk("apply_rst_count", fu({48'd0, count}, 0), 1);
    chk("apply_rst_y0", fu(s_y, 0), 300);
    chk("apply_rst_size0", fu(s_size, 0), 10);
    chk("apply_rst_angle0", fa(s_angle, 0), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("apply_rst_noedit", fu(s_x, 0), 400);
    do_frame();
    chk("post_rst_edit", fu(s_x, 0), 401);
    btn_held = 5'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
